// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state type, double-dabble constants and sizing helper for bin2bcd_seq.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

    // Decimal digits needed to show the largest unsigned value of the given width.
    function automatic int bcd_digits_for(input int width);
        longint unsigned v;
        int d;
        v = (64'd1 << width) - 64'd1;
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD digit of 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'(BCD_ADJ_THRESH)) ? d + 4'(BCD_ADJ_ADD) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one shift per clock.
// Define BIN2BCD_BLANK_EN to get a registered leading-zero blank mask.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    bin_in,
    input  logic                bin_valid,
    output logic                bin_ready,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                bcd_valid,
    output logic                ovf,
    output logic                busy,
    output logic [DIGITS-1:0]   blank
);

    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_t          state;
    logic [WIDTH-1:0]    sh;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] acc_adj;
    logic [4*DIGITS-1:0] acc_next;
    logic [CW-1:0]       cnt;
    logic                sticky;
    logic                carry;
    logic                last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(acc[4*i +: 4]),
            .q(acc_adj[4*i +: 4])
        );
    end

    assign carry     = acc_adj[4*DIGITS-1];
    assign acc_next  = {acc_adj[4*DIGITS-2:0], sh[WIDTH-1]};
    assign last      = cnt == CW'(WIDTH - 1);
    assign bin_ready = (state == IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: if (bin_valid) begin
                    sh     <= bin_in;
                    acc    <= '0;
                    cnt    <= '0;
                    sticky <= 1'b0;
                    busy   <= 1'b1;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    sh     <= sh << 1;
                    acc    <= acc_next;
                    cnt    <= cnt + CW'(1);
                    sticky <= sticky | carry;
                    if (last) begin
                        bcd_out   <= acc_next;
                        ovf       <= sticky | carry;
                        bcd_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              z;

    // Scan from the top digit down: a digit blanks while everything above it is zero.
    always_comb begin
        blank_nx = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z = z & (acc_next[4*i +: 4] == 4'd0);
            blank_nx[i] = z;
        end
        blank_nx[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            blank <= ~DIGITS'(1);
        else if (state == SHIFT && last)
            blank <= blank_nx;
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table-driven checks of bin2bcd_seq in 8/3, 8/2 and 1/1 configurations.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

`ifdef BIN2BCD_BLANK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bin [3];
    logic        vld [3];
    logic        rdy [3];
    logic        bv  [3];
    logic        ov  [3];
    logic        bsy [3];
    logic [11:0] bcd [3];
    logic [2:0]  blk [3];
    logic [7:0]  bcd_b;
    logic [3:0]  bcd_c;
    logic [1:0]  blk_b;
    logic        blk_c;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .bin_in(bin[0]), .bin_valid(vld[0]), .bin_ready(rdy[0]),
        .bcd_out(bcd[0]), .bcd_valid(bv[0]), .ovf(ov[0]), .busy(bsy[0]), .blank(blk[0])
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .bin_in(bin[1]), .bin_valid(vld[1]), .bin_ready(rdy[1]),
        .bcd_out(bcd_b), .bcd_valid(bv[1]), .ovf(ov[1]), .busy(bsy[1]), .blank(blk_b)
    );

    bin2bcd_seq #(.WIDTH(1), .DIGITS(1)) u_c (
        .clk(clk), .rst(rst), .bin_in(bin[2][0]), .bin_valid(vld[2]), .bin_ready(rdy[2]),
        .bcd_out(bcd_c), .bcd_valid(bv[2]), .ovf(ov[2]), .busy(bsy[2]), .blank(blk_c)
    );

    assign bcd[1] = {4'h0, bcd_b};
    assign bcd[2] = {8'h00, bcd_c};
    assign blk[1] = {1'b0, blk_b};
    assign blk[2] = {2'b00, blk_c};

    typedef struct {
        int          s;
        logic [7:0]  v;
        logic [11:0] bcd;
        logic        o;
        logic [2:0]  bl;
    } vec_t;

    vec_t tbl [16];
    logic [2:0] rst_blank [3];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    task automatic run(input int s, input logic [7:0] v, input logic [11:0] eb,
                       input logic eo, input logic [2:0] ebl);
        int w;
        int n;
        int lat;
        int bc;
        w = (s == 2) ? 1 : 8;
        n = 0;
        @(negedge clk);
        while (!rdy[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < 50), 1);
        bin[s] = v;
        vld[s] = 1'b1;
        @(negedge clk);
        vld[s] = 1'b0;
        lat = 1;
        bc = 0;
        while (!bv[s] && lat < 40) begin
            bc += int'(bsy[s]);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, w + 1);
        chk("busy_cycles", bc, w);
        chk("bcd_out", bcd[s], eb);
        chk("ovf", ov[s], eo);
        chk("blank", blk[s], BL ? ebl : 3'b000);
        chk("ready_in_done", rdy[s], 0);
        @(negedge clk);
        chk("valid_one_cycle", bv[s], 0);
        chk("ready_after_done", rdy[s], 1);
        chk("bcd_hold", bcd[s], eb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  vals [3];
        logic [11:0] r [3];
        logic [2:0]  rb [3];
        int at [3];
        int nacc;
        int nres;
        int pend;
        int seen;
        int n;

        tbl[0]  = '{0, 8'd0,   12'h000, 1'b0, 3'b110};
        tbl[1]  = '{0, 8'd255, 12'h255, 1'b0, 3'b000};
        tbl[2]  = '{0, 8'd1,   12'h001, 1'b0, 3'b110};
        tbl[3]  = '{0, 8'd5,   12'h005, 1'b0, 3'b110};
        tbl[4]  = '{0, 8'd50,  12'h050, 1'b0, 3'b100};
        tbl[5]  = '{0, 8'd100, 12'h100, 1'b0, 3'b000};
        tbl[6]  = '{0, 8'd128, 12'h128, 1'b0, 3'b000};
        tbl[7]  = '{0, 8'd199, 12'h199, 1'b0, 3'b000};
        tbl[8]  = '{1, 8'd123, 12'h023, 1'b1, 3'b000};
        tbl[9]  = '{1, 8'd42,  12'h042, 1'b0, 3'b000};
        tbl[10] = '{1, 8'd99,  12'h099, 1'b0, 3'b000};
        tbl[11] = '{1, 8'd100, 12'h000, 1'b1, 3'b010};
        tbl[12] = '{1, 8'd7,   12'h007, 1'b0, 3'b010};
        tbl[13] = '{2, 8'd1,   12'h001, 1'b0, 3'b000};
        tbl[14] = '{2, 8'd0,   12'h000, 1'b0, 3'b000};
        tbl[15] = '{2, 8'd1,   12'h001, 1'b0, 3'b000};
        rst_blank[0] = 3'b110;
        rst_blank[1] = 3'b010;
        rst_blank[2] = 3'b000;

        for (int s = 0; s < 3; s++) begin
            bin[s] = 8'd0;
            vld[s] = 1'b0;
        end

        chk("digits_for_8", bcd_digits_for(8), 3);
        chk("digits_for_10", bcd_digits_for(10), 4);
        chk("digits_for_1", bcd_digits_for(1), 1);

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_ready", rdy[s], 0);
            chk("rst_bcd", bcd[s], 0);
            chk("rst_valid", bv[s], 0);
            chk("rst_busy", bsy[s], 0);
            chk("rst_ovf", ov[s], 0);
            chk("rst_blank", blk[s], BL ? rst_blank[s] : 3'b000);
        end
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) chk("ready_after_rst", rdy[s], 1);

        for (int i = 0; i < 16; i++) run(tbl[i].s, tbl[i].v, tbl[i].bcd, tbl[i].o, tbl[i].bl);

        // back-to-back accepts with bin_valid held high
        vals[0] = 8'd9;
        vals[1] = 8'd10;
        vals[2] = 8'd99;
        nacc = 0;
        nres = 0;
        pend = 0;
        @(negedge clk);
        bin[0] = vals[0];
        vld[0] = 1'b1;
        for (int c = 0; c < 80 && nres < 3; c++) begin
            if (pend != 0) begin
                pend = 0;
                if (nacc < 3) bin[0] = vals[nacc];
                else vld[0] = 1'b0;
            end
            if (rdy[0] && vld[0] && nacc < 3) begin
                at[nacc] = c;
                nacc++;
                pend = 1;
            end
            if (bv[0]) begin
                r[nres] = bcd[0];
                rb[nres] = blk[0];
                nres++;
            end
            @(negedge clk);
        end
        vld[0] = 1'b0;
        chk("b2b_results", nres, 3);
        chk("b2b_gap1", at[1] - at[0], 10);
        chk("b2b_gap2", at[2] - at[1], 10);
        chk("b2b_r0", r[0], 12'h009);
        chk("b2b_r1", r[1], 12'h010);
        chk("b2b_r2", r[2], 12'h099);
        chk("b2b_bl0", rb[0], BL ? 3'b110 : 3'b000);
        chk("b2b_bl1", rb[1], BL ? 3'b100 : 3'b000);
        chk("b2b_bl2", rb[2], BL ? 3'b100 : 3'b000);

        // bin_valid pulses during SHIFT and DONE must be ignored
        @(negedge clk);
        bin[0] = 8'd77;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        bin[0] = 8'd33;
        vld[0] = 1'b1;
        chk("no_ready_shift", rdy[0], 0);
        @(negedge clk);
        vld[0] = 1'b0;
        chk("bcd_held_shift", bcd[0], 12'h099);
        n = 0;
        while (!bv[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ign_done_seen", 32'(n < 40), 1);
        chk("ign_result", bcd[0], 12'h077);
        bin[0] = 8'd33;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("ign_idle_ready", rdy[0], 1);
        seen = 0;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            seen += int'(bv[0]);
            n += int'(bsy[0]);
        end
        chk("ign_no_pulse", seen, 0);
        chk("ign_no_busy", n, 0);
        chk("ign_bcd_stable", bcd[0], 12'h077);

        // reset four cycles into a conversion of 200
        seen = 0;
        @(negedge clk);
        bin[0] = 8'd200;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (3) begin
            seen += int'(bv[0]);
            @(negedge clk);
        end
        seen += int'(bv[0]);
        rst = 1'b1;
        #1;
        chk("ready_low_in_rst", rdy[0], 0);
        @(negedge clk);
        chk("ready_low_in_rst2", rdy[0], 0);
        seen += int'(bv[0]);
        rst = 1'b0;
        #1;
        chk("midrst_ready", rdy[0], 1);
        chk("midrst_bcd", bcd[0], 0);
        chk("midrst_ovf", ov[0], 0);
        chk("midrst_busy", bsy[0], 0);
        chk("midrst_blank", blk[0], BL ? 3'b110 : 3'b000);
        repeat (12) begin
            @(negedge clk);
            seen += int'(bv[0]);
        end
        chk("midrst_no_pulse", seen, 0);
        chk("midrst_bcd_stable", bcd[0], 0);
        run(0, 8'd200, 12'h200, 1'b0, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that consumes the binary `count` produced by the lab counter and delivers packed BCD digits to the seven-segment display driver. It implements iterative double-dabble: one shift-and-adjust step per clock, with a valid/ready handshake on the input and a one-cycle result strobe on the output. The last result is held stable between conversions so the display never sees intermediate values.

## Interface
- `WIDTH`, default 8: width of the binary input.
- `DIGITS`, default 3: number of BCD output digits. Must be ≥ 1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bin_in` in `WIDTH`: binary value to convert; sampled on accept.
- `bin_valid` in 1: `bin_in` is valid.
- `bin_ready` out 1: the block can accept a value. High only in IDLE and only when `rst` is low.
- `bcd_out` out `4*DIGITS`: packed BCD result, digit 0 in bits [3:0]. Holds the last completed result.
- `bcd_valid` out 1: one-cycle pulse; `bcd_out` and `ovf` were updated this cycle.
- `ovf` out 1: the last result exceeded 10^DIGITS−1; `bcd_out` holds the low DIGITS digits.
- `busy` out 1: high in the SHIFT state.
- `blank` out `DIGITS`: leading-zero mask; see Configuration.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - Accept when `bin_valid & bin_ready`.
  - On accept, load `bin_in` into the shift register, clear the BCD accumulator and step counter, and go to SHIFT.
- **SHIFT** (one step per cycle, `WIDTH` steps total)
  - Each cycle, every accumulator digit ≥ 5 gets +3.
  - Then `{carry, accumulator, binary}` shifts left by 1.
  - Any bit shifted out of the top digit sets the sticky overflow flag for this conversion.
  - On the final step (step counter = `WIDTH`−1), the adjusted and shifted accumulator is written to `bcd_out`, the sticky flag to `ovf`, and `bcd_valid` is set. Next state is DONE.
- **DONE**: lasts exactly 1 cycle. `bcd_valid` is high and `bin_ready` is low. Next state is IDLE.
- `bin_valid` is ignored outside IDLE. There is no queuing; the upstream stage holds its value until it is accepted.
- Step counter width is `$clog2(WIDTH+1)`. The counter never wraps within a conversion.
- **Reset** (including mid-conversion):
  - Next state is IDLE; the in-flight conversion is discarded.
  - `bcd_out`=0, `ovf`=0, `bcd_valid`=0, `busy`=0, `blank` = all digits except digit 0 set (or 0 without the macro).
  - `bin_ready` is 0 while `rst` is high and 1 on the first cycle after reset is released.
- `WIDTH`=1 is legal: one SHIFT cycle.

## Timing
- Accept at edge T (IDLE, handshake true): SHIFT occupies cycles T+1 … T+WIDTH.
- `bcd_valid`=1 and new `bcd_out` appear in cycle T+WIDTH+1 (DONE).
- `bin_ready`=1 again in cycle T+WIDTH+2.
- Latency from accept to `bcd_valid` is WIDTH+1 cycles. Throughput is one conversion per WIDTH+2 cycles; with `bin_valid` held high, accepts occur every WIDTH+2 cycles.
- `bcd_out`, `ovf`, and `blank` change only in the cycle `bcd_valid` is high, or on reset.
- All outputs are registered except `bin_ready` (decoded from state and `rst`).

## Configuration
- Macro: `BIN2BCD_BLANK_EN`.
- **Defined**
  - `blank[i]`=1 when digit i and all higher digits are zero, for i ≥ 1.
  - `blank[0]` is always 0, so a zero value shows a single "0".
  - `blank` is registered and updated with `bcd_out`.
- **Undefined**: `blank` is tied to all-zero, with no extra logic.

## Structure
- Package `bin2bcd_pkg`:
  - state enum `bcd_state_t` {IDLE, SHIFT, DONE};
  - constant `BCD_ADJ_THRESH`=5 and `BCD_ADJ_ADD`=3;
  - function `bcd_digits_for(width)` returning the minimum DIGITS for a given width (benches use it to size their checks).
- Sub-module `bcd_digit_adj`: combinational, 4-bit in → 4-bit out; adds 3 when the input is ≥ 5. Instantiated `DIGITS` times by a generate loop.

## Test plan
- Reset, then `bin_in`=0 accepted → after 9 cycles `bcd_out`=12'h000, `ovf`=0; `blank`=3'b110 with the macro.
- `bin_in`=255 (WIDTH 8, DIGITS 3) → `bcd_out`=12'h255 exactly WIDTH+1 cycles after accept; `bcd_valid` high 1 cycle; `busy` high 8 cycles.
- `bin_valid` held high, counter values 9, 10, 99 presented back-to-back → accepts 10 cycles apart; outputs 12'h009, 12'h010, 12'h099; `blank` 3'b110, 3'b100, 3'b100.
- `rst` asserted 4 cycles into a conversion of 200 → `bcd_valid` never pulses for 200; next cycle after release `bin_ready`=1, `bcd_out`=0.
- DIGITS=2, `bin_in`=123 → `bcd_out`=8'h23, `ovf`=1; a following conversion of 42 → 8'h42, `ovf`=0.
- `bin_valid` pulsed during SHIFT and DONE → ignored; `bcd_out` is unchanged apart from the in-flight result.
